// File: rtl/mulmod_serial_pkg.sv
// Shared constants and types for the bit-serial GF(2^255-19) multiplier.
package mulmod_serial_pkg;

    localparam int unsigned W  = 255;
    localparam int unsigned AW = 256;
    localparam int unsigned CW = 8;

    localparam logic [AW-1:0] P25519 = (AW'(1) << W) - AW'(19);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDUCE,
        S_LOOP,
        S_DONE
    } state_t;

    // Single conditional subtract of p; valid for any v < 2p.
    function automatic logic [AW-1:0] red_p(input logic [AW-1:0] v);
        return (v >= P25519) ? v - P25519 : v;
    endfunction

endpackage

// File: rtl/mulmod_serial_mod_dbl_add.sv
// One MSB-first double-and-add step: s = (2*acc + bit*a) mod p, with acc, a < p.
module mod_dbl_add
    import mulmod_serial_pkg::*;
(
    input  logic [AW-1:0] acc,
    input  logic [AW-1:0] a,
    input  logic          b_bit,
    output logic [AW-1:0] s
);

    logic [AW-1:0] d;

    // acc < p, so acc+acc < 2^256 and both sums stay below 2p.
    always_comb begin
        d = red_p(acc + acc);
        s = red_p(d + (b_bit ? a : '0));
    end

endmodule

// File: rtl/mulmod_serial.sv
// Bit-serial Z = X*Y mod (2^255-19) behind the field-op request/result handshake.
// Define MULMOD_SERIAL_TWO_BIT_EN to retire two multiplier bits per LOOP cycle.
module mulmod_serial
    import mulmod_serial_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [254:0] X,
    input  logic [254:0] Y,
    output logic [254:0] Z,
    input  logic         req_valid,
    output logic         req_ready,
    output logic         req_busy,
    output logic         res_valid,
    input  logic         res_ready
);

`ifdef MULMOD_SERIAL_TWO_BIT_EN
    localparam logic [CW-1:0] CNT_START = CW'(255);
    localparam logic [CW-1:0] CNT_STEP  = CW'(2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(1);
`else
    localparam logic [CW-1:0] CNT_START = CW'(254);
    localparam logic [CW-1:0] CNT_STEP  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(0);
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] b_q, b_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  z_q, z_d;
    logic          req_ready_q, req_ready_d;
    logic          req_busy_q, req_busy_d;
    logic          res_valid_q, res_valid_d;

    logic [AW-1:0] s1;
    logic [AW-1:0] step;

    mod_dbl_add u_step0 (
        .acc   (acc_q),
        .a     (a_q),
        .b_bit (b_q[cnt_q]),
        .s     (s1)
    );

`ifdef MULMOD_SERIAL_TWO_BIT_EN
    logic [AW-1:0] s2;

    mod_dbl_add u_step1 (
        .acc   (s1),
        .a     (a_q),
        .b_bit (b_q[cnt_q - CW'(1)]),
        .s     (s2)
    );

    assign step = s2;
`else
    assign step = s1;
`endif

    assign Z         = z_q;
    assign req_ready = req_ready_q;
    assign req_busy  = req_busy_q;
    assign res_valid = res_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            z_q         <= '0;
            req_ready_q <= 1'b0;
            req_busy_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            z_q         <= z_d;
            req_ready_q <= req_ready_d;
            req_busy_q  <= req_busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Next-state and output logic; req_ready defaults low so it is a single-cycle pulse.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        z_d         = z_q;
        req_ready_d = 1'b0;
        req_busy_d  = req_busy_q;
        res_valid_d = res_valid_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d         = {1'b0, X};
                    b_d         = {1'b0, Y};
                    req_ready_d = 1'b1;
                    req_busy_d  = 1'b1;
                    state_d     = S_REDUCE;
                end
            end
            S_REDUCE: begin
                a_d     = red_p(a_q);
                b_d     = red_p(b_q);
                acc_d   = '0;
                cnt_d   = CNT_START;
                state_d = S_LOOP;
            end
            S_LOOP: begin
                acc_d = step;
                cnt_d = cnt_q - CNT_STEP;
                if (cnt_q == CNT_LAST) begin
                    z_d         = step[W-1:0];
                    req_busy_d  = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mulmod_serial.sv
// Directed bench for mulmod_serial: values, handshake timing, back-pressure and async reset.
module tb_mulmod_serial;

    localparam logic [254:0] ALL1 = {255{1'b1}};
    localparam logic [254:0] P_M1 = ALL1 - 255'd19;
    localparam logic [254:0] P_M2 = ALL1 - 255'd20;
`ifdef MULMOD_SERIAL_TWO_BIT_EN
    localparam int EXP_LAT = 129;
`else
    localparam int EXP_LAT = 256;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [254:0] X, Y, Z;
    logic         req_valid, req_ready, req_busy, res_valid, res_ready;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;

    mulmod_serial dut (
        .clk       (clk),
        .rst       (rst),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_busy  (req_busy),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (req_ready) n_acc++;

    task automatic check(input string tag, input logic [254:0] got, input logic [254:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present operands and wait (bounded) for the accept pulse; optionally keep req_valid up.
    task automatic accept(input logic [254:0] x, input logic [254:0] y, input logic keep);
        int n;
        n = 0;
        X = x;
        Y = y;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            tick;
            n++;
        end
        check("accept", 255'(req_ready), 255'(1));
        if (!keep) req_valid = 1'b0;
    endtask

    // Cycles from the accept sample until res_valid is seen, plus handshake observations.
    task automatic wait_result(output int lat, output logic busy_prev, output logic rdy_next);
        lat       = 0;
        busy_prev = req_busy;
        rdy_next  = 1'b1;
        while (!res_valid && lat < 600) begin
            busy_prev = req_busy;
            tick;
            lat++;
            if (lat == 1) rdy_next = req_ready;
        end
    endtask

    logic [254:0] vx [4];
    logic [254:0] vy [4];
    logic [254:0] vz [4];
    logic [254:0] px [3];
    logic [254:0] py [3];
    logic [254:0] pz [3];

    initial begin
        int   lat;
        int   a0;
        logic busy_prev, rdy_next, stable, early;

        vx[0] = P_M1; vy[0] = P_M1; vz[0] = 255'd1;
        vx[1] = 255'd1; vy[1] = P_M1; vz[1] = P_M1;
        vx[2] = 255'd0; vy[2] = P_M1; vz[2] = 255'd0;
        vx[3] = ALL1;   vy[3] = 255'd2; vz[3] = 255'd36;
        px[0] = 255'd7;         py[0] = 255'd11;        pz[0] = 255'd77;
        px[1] = P_M1;           py[1] = 255'd2;         pz[1] = P_M2;
        px[2] = 255'd123456789; py[2] = 255'd987654321; pz[2] = 255'd121932631112635269;

        rst = 1'b1;
        req_valid = 1'b0;
        res_ready = 1'b0;
        X = '0;
        Y = '0;
        repeat (3) tick;
        check("rst_z", Z, 255'd0);
        check("rst_req_ready", 255'(req_ready), 255'd0);
        check("rst_req_busy", 255'(req_busy), 255'd0);
        check("rst_res_valid", 255'(res_valid), 255'd0);
        rst = 1'b0;
        tick;

        // Basic product with res_ready tied high
        res_ready = 1'b1;
        accept(255'd2, 255'd3, 1'b0);
        check("busy_on_accept", 255'(req_busy), 255'd1);
        wait_result(lat, busy_prev, rdy_next);
        check("z_2x3", Z, 255'd6);
        check("ready_pulse", 255'(rdy_next), 255'd0);
        check("latency", 255'(lat), 255'(EXP_LAT));
        check("busy_before_res", 255'(busy_prev), 255'd1);
        check("busy_fall", 255'(req_busy), 255'd0);
        tick;
        check("res_valid_one_cycle", 255'(res_valid), 255'd0);

        // Boundary operand vectors
        for (int i = 0; i < 4; i++) begin
            accept(vx[i], vy[i], 1'b0);
            wait_result(lat, busy_prev, rdy_next);
            check($sformatf("vec%0d", i), Z, vz[i]);
        end

        // Result back-pressure with a pending request during S_DONE
        tick;
        res_ready = 1'b0;
        accept(255'd3, 255'd4, 1'b0);
        wait_result(lat, busy_prev, rdy_next);
        check("z_3x4", Z, 255'd12);
        stable = 1'b1;
        early  = 1'b0;
        X = 255'd5;
        Y = 255'd6;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (res_valid !== 1'b1 || Z !== 255'd12) stable = 1'b0;
            if (req_ready) early = 1'b1;
        end
        check("done_hold", 255'(stable), 255'd1);
        check("no_early_accept", 255'(early), 255'd0);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check("res_drop", 255'(res_valid), 255'd0);
        check("not_yet_accepted", 255'(req_ready), 255'd0);
        tick;
        check("accept_after_hs", 255'(req_ready), 255'd1);
        req_valid = 1'b0;
        wait_result(lat, busy_prev, rdy_next);
        check("z_5x6", Z, 255'd30);

        // Point-add style initiator: overlapping res_ready pulse and next request
        a0 = n_acc;
        for (int i = 0; i < 3; i++) begin
            res_ready = 1'b1;
            accept(px[i], py[i], 1'b1);
            res_ready = 1'b0;
            tick;
            req_valid = 1'b0;
            wait_result(lat, busy_prev, rdy_next);
            check($sformatf("b2b%0d", i), Z, pz[i]);
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check("b2b_accepts", 255'(n_acc - a0), 255'd3);

        // Asynchronous reset in the middle of the loop
        accept(255'd9, 255'd9, 1'b0);
        repeat (101) tick;
        check("busy_mid_loop", 255'(req_busy), 255'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_z", Z, 255'd0);
        check("arst_req_ready", 255'(req_ready), 255'd0);
        check("arst_req_busy", 255'(req_busy), 255'd0);
        check("arst_res_valid", 255'(res_valid), 255'd0);
        repeat (2) tick;
        rst = 1'b0;
        tick;
        res_ready = 1'b1;
        accept(255'd5, 255'd7, 1'b0);
        wait_result(lat, busy_prev, rdy_next);
        check("z_5x7", Z, 255'd35);
        check("latency_after_rst", 255'(lat), 255'(EXP_LAT));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
